// File: rtl/mul_pkg.sv
// Shared types and constants for the RV64M multiply sequencing front-end.
package mul_pkg;

  localparam int MULW_BITS = 32;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } mul_state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Applies sign correction to the unsigned core product and selects the low,
// high or sign-extended word half of the corrected product.
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic               neg,
  input  logic [1:0]         op,
  input  logic               word,
  output logic [WIDTH-1:0]   resp_data
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] p;

  always_comb begin
    p = neg ? (~mul_result + PW'(1)) : mul_result;
    resp_data = p[WIDTH-1:0];
    case (mul_op_e'(op))
      MUL: begin
        if (word) begin
          resp_data = {{(WIDTH-MULW_BITS){p[MULW_BITS-1]}}, p[MULW_BITS-1:0]};
        end
      end
      MULH, MULHSU, MULHU: resp_data = p[PW-1:WIDTH];
      default: resp_data = p[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer between EX-stage issue and the unsigned pipelined multiplier core:
// operand conditioning, start pulse, result capture and writeback handshake.
//
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | mul_start pulsed to the core this cycle
//   WAIT  | waiting for mul_ready of the live operation
//   DONE  | result presented to writeback until resp_ready
//   DRAIN | flushed op still in the core; swallow its mul_ready
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic                 req_word,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic [TAG_W-1:0]     resp_tag,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_start,
  input  logic [2*WIDTH-1:0]   mul_result,
  input  logic                 mul_ready
);

  mul_state_e        state;
  mul_state_e        state_next;
  mul_op_e           op_q;
  logic              word_q;
  logic              neg_q;
  logic [TAG_W-1:0]  tag_q;

  mul_op_e           op_in;
  logic              word_eff;
  logic              a_signed;
  logic              b_signed;
  logic [WIDTH-1:0]  a_ext;
  logic [WIDTH-1:0]  b_ext;
  logic              a_neg;
  logic              b_neg;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;

  logic              accept;
  logic              capture;
  logic [WIDTH-1:0]  fix_data;

  assign req_ready = (state == IDLE) & ~flush & ~reset;
  assign accept    = req_valid & req_ready;
  assign capture   = (state == WAIT) & mul_ready & ~flush;

  always_comb begin
    op_in    = mul_op_e'(req_op);
    word_eff = req_word & (op_in == MUL);
    a_signed = (op_in == MULH) | (op_in == MULHSU) | word_eff;
    b_signed = (op_in == MULH) | word_eff;
    a_ext    = req_a;
    b_ext    = req_b;
    if (word_eff) begin
      a_ext = {{(WIDTH-MULW_BITS){req_a[MULW_BITS-1]}}, req_a[MULW_BITS-1:0]};
      b_ext = {{(WIDTH-MULW_BITS){req_b[MULW_BITS-1]}}, req_b[MULW_BITS-1:0]};
    end
    a_neg = a_signed & a_ext[WIDTH-1];
    b_neg = b_signed & b_ext[WIDTH-1];
    // Most-negative input negates to itself, which is the correct unsigned magnitude.
    a_mag = a_neg ? (~a_ext + WIDTH'(1)) : a_ext;
    b_mag = b_neg ? (~b_ext + WIDTH'(1)) : b_ext;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        // A flush landing on the product cycle has nothing left to drain.
        if (flush) state_next = mul_ready ? IDLE : DRAIN;
        else if (mul_ready) state_next = DONE;
      end
      DONE: begin
        if (flush || resp_ready) state_next = IDLE;
      end
      DRAIN: begin
        if (mul_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  mul_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .mul_result (mul_result),
    .neg        (neg_q),
    .op         (op_q),
    .word       (word_q),
    .resp_data  (fix_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_start  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      op_q       <= MUL;
      word_q     <= 1'b0;
      neg_q      <= 1'b0;
      tag_q      <= '0;
    end else begin
      mul_start  <= (state_next == ISSUE);
      resp_valid <= (state_next == DONE);
      if (accept) begin
        mul_a  <= a_mag;
        mul_b  <= b_mag;
        op_q   <= op_in;
        word_q <= word_eff;
        neg_q  <= a_neg ^ b_neg;
        tag_q  <= req_tag;
      end
      if (capture) begin
        resp_data <= fix_data;
        resp_tag  <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a latency-3 multiplier core model and a
// tag/data scoreboard checked at each writeback handshake.
module tb_mul_ctrl;
  import mul_pkg::*;

  localparam int WIDTH = 64;
  localparam int TAG_W = 5;
  localparam int LAT   = 3;

  logic               clk;
  logic               reset;
  logic               flush;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic               req_word;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic [TAG_W-1:0]   req_tag;
  logic               resp_valid;
  logic               resp_ready;
  logic [WIDTH-1:0]   resp_data;
  logic [TAG_W-1:0]   resp_tag;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_start;
  logic [2*WIDTH-1:0] mul_result;
  logic               mul_ready;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mul_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_word   (req_word),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_result (mul_result),
    .mul_ready  (mul_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unsigned pipelined core: start sampled at edge E, ready in the cycle after E+LAT-1.
  logic [LAT-1:0]     pv;
  logic [2*WIDTH-1:0] pp [LAT];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pp[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mul_start};
      pp[0] <= {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
      for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
    end
  end

  assign mul_ready  = pv[LAT-1];
  assign mul_result = pp[LAT-1];

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic word,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp_data,
                        input logic [WIDTH-1:0] exp_ma, input logic [WIDTH-1:0] exp_mb,
                        input int hold);
    exp_t             e;
    logic             acc;
    int               lat;
    int               starts;
    logic [WIDTH-1:0] d0;
    logic [TAG_W-1:0] t0;
    e.tag  = tag;
    e.data = exp_data;
    sb.push_back(e);
    req_op     = op;
    req_word   = word;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = req_ready;
      @(posedge clk);
    end
    chk("accept", acc, 1);
    lat    = 0;
    starts = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = 1'b0;
      if (mul_start) begin
        starts++;
        chk("mul_a", mul_a, exp_ma);
        chk("mul_b", mul_b, exp_mb);
      end
    end while (!resp_valid && lat < 60);
    chk("resp_valid_seen", resp_valid, 1);
    chk("latency", lat, LAT + 2);
    chk("start_pulses", starts, 1);
    d0 = resp_data;
    t0 = resp_tag;
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, d0);
      chk("hold_tag", resp_tag, t0);
      chk("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("resp_data", resp_data, e.data);
      chk("resp_tag", resp_tag, e.tag);
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic bad;
    int   starts;
    reset      = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_word   = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    resp_ready = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_resp_data", resp_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1);
    chk("idle_mul_a", mul_a, 0);
    @(negedge clk);

    run_op(MULH, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd5, 0);
    run_op(MUL, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd2,
           64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0);
    run_op(MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3,
           64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(MULHSU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd2, 0);
    run_op(MULH, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd5,
           64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    run_op(MUL, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_7FFF_FFFF, 64'd2, 0);
    run_op(MUL, 1, 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFF, 5'd7,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd3, 64'd1, 0);

    // writeback backpressure, then an immediate follow-on request
    run_op(MUL, 0, 64'h1234, 64'h10, 5'h1F, 64'h12340, 64'h1234, 64'h10, 5);
    run_op(MULHU, 0, 64'h8000_0000_0000_0000, 64'd4, 5'd10,
           64'd2, 64'h8000_0000_0000_0000, 64'd4, 0);

    // flush during WAIT, drain the stale product
    req_op    = MUL;
    req_word  = 1'b0;
    req_a     = 64'd11;
    req_b     = 64'd13;
    req_tag   = 5'd3;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("flush_issue_start", mul_start, 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    bad  = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (resp_valid || req_ready) bad = 1'b1;
      if (mul_ready) seen = 1'b1;
      else @(negedge clk);
    end
    chk("drain_stale_ready", seen, 1);
    chk("drain_quiet", bad, 0);
    @(negedge clk);
    chk("drain_exit_req_ready", req_ready, 1);
    chk("drain_exit_valid", resp_valid, 0);
    run_op(MUL, 0, 64'd7, 64'd6, 5'd9, 64'd42, 64'd7, 64'd6, 0);

    // flush with a coincident request in IDLE drops the request
    req_op    = MUL;
    req_a     = 64'd2;
    req_b     = 64'd2;
    req_tag   = 5'd12;
    req_valid = 1'b1;
    flush     = 1'b1;
    #1;
    chk("flush_idle_req_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    starts = 0;
    bad    = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (mul_start) starts++;
      if (resp_valid) bad = 1'b1;
      @(negedge clk);
    end
    chk("flush_idle_no_start", starts, 0);
    chk("flush_idle_no_resp", bad, 0);
    chk("flush_idle_req_ready_after", req_ready, 1);

    // reset in the middle of WAIT
    req_op    = MUL;
    req_a     = 64'd5;
    req_b     = 64'd5;
    req_tag   = 5'd2;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_mul_a", mul_a, 0);
    chk("async_rst_mul_b", mul_b, 0);
    chk("async_rst_resp_data", resp_data, 0);
    chk("async_rst_resp_tag", resp_tag, 0);
    chk("async_rst_resp_valid", resp_valid, 0);
    chk("async_rst_mul_start", mul_start, 0);
    chk("async_rst_req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);
    @(negedge clk);
    run_op(MUL, 0, 64'd3, 64'd3, 5'd4, 64'd9, 64'd3, 64'd3, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
